// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the M-stage store buffer: store op encodings,
// exception code, address-map bounds, FIFO entry layout and small helpers.
package m_store_buffer_pkg;

    // Store op encodings carried on the 32-bit st_op bus
    localparam logic [31:0] STORE_NONE = 32'd0;
    localparam logic [31:0] STORE_W    = 32'd1;
    localparam logic [31:0] STORE_H    = 32'd2;
    localparam logic [31:0] STORE_B    = 32'd3;

    // Exception codes reported on st_exc
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Address map: data memory, two timers and the interrupt generator
    localparam logic [31:0] DM_LO     = 32'h0000_0000;
    localparam logic [31:0] DM_HI     = 32'h0000_2FFF;
    localparam logic [31:0] TIMER0_LO = 32'h0000_7F00;
    localparam logic [31:0] TIMER0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TIMER1_LO = 32'h0000_7F10;
    localparam logic [31:0] TIMER1_HI = 32'h0000_7F1B;
    localparam logic [31:0] IG_LO     = 32'h0000_7F20;
    localparam logic [31:0] IG_HI     = 32'h0000_7F23;

    // Offset of the read-only COUNT register inside each timer block
    localparam logic [31:0] TIMER_COUNT_OFF = 32'h0000_0008;

    // Access width decoded from st_op
    typedef enum logic [1:0] {
        SIZE_NONE,
        SIZE_B,
        SIZE_H,
        SIZE_W
    } st_size_e;

    // One buffered store: word address plus lane-aligned data and enables
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } sb_entry_t;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Unknown encodings are treated like STORE_NONE so they never reach the bus
    function automatic st_size_e decode_op(input logic [31:0] op);
        st_size_e s;
        case (op)
            STORE_W: s = SIZE_W;
            STORE_H: s = SIZE_H;
            STORE_B: s = SIZE_B;
            default: s = SIZE_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/m_store_buffer_if.sv
// Pipeline-side and bus-side signals of the M-stage store buffer.
// slave: the store buffer itself; master: the pipeline/bridge driving it.
interface m_store_buffer_if;

    logic        st_valid;
    logic [31:0] st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        flush;
    logic [31:0] ld_addr;
    logic        ld_valid;
    logic        st_stall;
    logic [4:0]  st_exc;
    logic        ld_stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        bus_ready;

    modport slave (
        input  st_valid, st_op, st_addr, st_data, flush, ld_addr, ld_valid, bus_ready,
        output st_stall, st_exc, ld_stall, bus_req, bus_addr, bus_wdata, bus_byteen
    );

    modport master (
        output st_valid, st_op, st_addr, st_data, flush, ld_addr, ld_valid, bus_ready,
        input  st_stall, st_exc, ld_stall, bus_req, bus_addr, bus_wdata, bus_byteen
    );

endinterface

// File: rtl/m_store_buffer_align.sv
// m_store_align: combinational store legality check and byte-lane packing.
// Maps (op, addr, data) to lane enables, replicated write data and AdES.
module m_store_align
    import m_store_buffer_pkg::*;
(
    input  logic [31:0] st_op_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    output logic        store_o,
    output logic [3:0]  byteen_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  exc_o
);

    st_size_e size;
    logic     in_timer;
    logic     in_map;
    logic     bad;

    // Decode width, pack lanes and flag any illegal address for this width
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        size     = decode_op(st_op_i);
        store_o  = (size != SIZE_NONE);
        byteen_o = 4'b0000;
        wdata_o  = 32'h0;
        exc_o    = EXC_NONE;
        bad      = 1'b0;

        in_timer = in_range(st_addr_i, TIMER0_LO, TIMER0_HI) ||
                   in_range(st_addr_i, TIMER1_LO, TIMER1_HI);
        in_map   = in_range(st_addr_i, DM_LO, DM_HI) || in_timer ||
                   in_range(st_addr_i, IG_LO, IG_HI);

        case (size)
            SIZE_W: begin
                byteen_o = 4'b1111;
                wdata_o  = st_data_i;
                // Timer COUNT registers are read-only
                bad      = (st_addr_i[1:0] != 2'b00) ||
                           (st_addr_i == TIMER0_LO + TIMER_COUNT_OFF) ||
                           (st_addr_i == TIMER1_LO + TIMER_COUNT_OFF);
            end
            SIZE_H: begin
                byteen_o = 4'b0011 << {st_addr_i[1], 1'b0};
                wdata_o  = {2{st_data_i[15:0]}};
                bad      = st_addr_i[0] || in_timer;
            end
            SIZE_B: begin
                byteen_o = 4'b0001 << st_addr_i[1:0];
                wdata_o  = {4{st_data_i[7:0]}};
                bad      = in_timer;
            end
            default: ;
        endcase

        if (store_o && (bad || !in_map)) begin
            exc_o = EXC_ADES;
        end
    end

endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: M-stage store path. Legal stores are packed into byte lanes
// and queued in a DEPTH-entry FIFO that drains to the bus bridge over
// bus_req/bus_ready. Optional macro STORE_LOAD_HAZARD_EN builds the
// load-vs-buffered-store word-address comparators driving ld_stall.
module m_store_buffer
    import m_store_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    m_store_buffer_if.slave   sb_if
);

    logic              a_store;
    logic [3:0]        a_byteen;
    logic [31:0]       a_wdata;
    logic [4:0]        a_exc;

    logic              active;
    logic              legal;
    logic              full;
    logic              pop;
    logic              push;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    sb_entry_t         mem_q [DEPTH];
    sb_entry_t         new_entry;
    sb_entry_t         head;

    m_store_align u_align (
        .st_op_i   (sb_if.st_op),
        .st_addr_i (sb_if.st_addr),
        .st_data_i (sb_if.st_data),
        .store_o   (a_store),
        .byteen_o  (a_byteen),
        .wdata_o   (a_wdata),
        .exc_o     (a_exc)
    );

    // An excepting or flushed store is dropped and never stalls
    assign active = sb_if.st_valid && a_store;
    assign legal  = active && (a_exc == EXC_NONE) && !sb_if.flush;
    assign full   = (count_q == (PTR_W+1)'(DEPTH));

    assign sb_if.bus_req = valid_q[rd_ptr_q];
    assign pop           = sb_if.bus_req && sb_if.bus_ready;

    // A pop while full frees the slot in the same cycle
    assign sb_if.st_stall = legal && full && !pop;
    assign push           = legal && !sb_if.st_stall;
    assign sb_if.st_exc   = active ? a_exc : EXC_NONE;

    assign new_entry = '{waddr: sb_if.st_addr[31:2], wdata: a_wdata, byteen: a_byteen};

    // Head entry drives the bus straight from storage, so it is stable while waiting
    assign head             = mem_q[rd_ptr_q];
    assign sb_if.bus_addr   = {head.waddr, 2'b00};
    assign sb_if.bus_wdata  = head.wdata;
    assign sb_if.bus_byteen = head.byteen;

    // Next pointers, occupancy and per-entry valid bits from push/pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        // Applied after the pop so push-into-just-freed-slot leaves it valid
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset drops any pending entries
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage, written at the tail on push
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the storage is reset on purpose: it is only a few entries and the bus outputs read it directly, so they come up 0.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

`ifdef STORE_LOAD_HAZARD_EN
    logic ld_hit;
    logic unused_ld_low;

    // A load stalls while any buffered store targets the same word
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i].waddr == sb_if.ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign sb_if.ld_stall = sb_if.ld_valid && ld_hit;
    assign unused_ld_low  = ^sb_if.ld_addr[1:0];
`else
    logic unused_ld;

    assign sb_if.ld_stall = 1'b0;
    assign unused_ld      = ^{sb_if.ld_valid, sb_if.ld_addr};
`endif

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed steps followed by a random
// phase, all checked against a queue-based reference model of the buffer.
module tb_m_store_buffer;
    import m_store_buffer_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    m_store_buffer_if sb_if ();

    m_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb_if (sb_if)
    );

    exp_t q[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    task automatic check(input string tag, input string field,
                         input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s.%s: observed 0x%08h expected 0x%08h", tag, field, obs, exp);
        end
    endtask

    // Bytes written by an op; 0 means no store
    function automatic int op_size(input logic [31:0] op);
        if (op == STORE_W) return 4;
        if (op == STORE_H) return 2;
        if (op == STORE_B) return 1;
        return 0;
    endfunction

    function automatic bit model_ades(input logic [31:0] a, input int size);
        bit mapped = 0;
        bit timer  = 0;
        if (a <= 32'h2FFF) mapped = 1;
        if (a >= 32'h7F00 && a <= 32'h7F0B) begin mapped = 1; timer = 1; end
        if (a >= 32'h7F10 && a <= 32'h7F1B) begin mapped = 1; timer = 1; end
        if (a >= 32'h7F20 && a <= 32'h7F23) mapped = 1;
        if (!mapped) return 1;
        if (a % size != 0) return 1;
        if (timer && size != 4) return 1;
        if (timer && (a % 16 == 8)) return 1;
        return 0;
    endfunction

    // Lane i is enabled when it falls inside [offset, offset+size); its byte
    // is data byte (i mod size), which replicates halves and bytes.
    function automatic exp_t model_pack(input logic [31:0] a, input logic [31:0] d, input int size);
        exp_t e;
        int   off;
        off    = a % 4;
        e.addr = {a[31:2], 2'b00};
        e.be   = 4'b0000;
        e.data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) e.be[i] = 1'b1;
            e.data[8*i +: 8] = d[8*(i % size) +: 8];
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic fl, input logic rdy,
                         input logic ldv, input logic [31:0] lda);
        sb_if.st_valid  = v;
        sb_if.st_op     = op;
        sb_if.st_addr   = a;
        sb_if.st_data   = d;
        sb_if.flush     = fl;
        sb_if.bus_ready = rdy;
        sb_if.ld_valid  = ldv;
        sb_if.ld_addr   = lda;
    endtask

    // Check one cycle against the model, then advance the clock and the model.
    // Called right after a falling edge with inputs already driven.
    task automatic step(input string tag);
        int   size;
        bit   active, ades, pop, full, stall, push, haz;
        exp_t e;
        #1;
        size   = op_size(sb_if.st_op);
        active = sb_if.st_valid && (size != 0);
        ades   = active && model_ades(sb_if.st_addr, size);
        pop    = (q.size() > 0) && sb_if.bus_ready;
        full   = (q.size() == DEPTH);
        stall  = active && !ades && !sb_if.flush && full && !pop;
        push   = active && !ades && !sb_if.flush && !stall;
        haz    = 0;
`ifdef STORE_LOAD_HAZARD_EN
        foreach (q[i]) if (q[i].addr[31:2] == sb_if.ld_addr[31:2]) haz = 1;
        haz = haz && sb_if.ld_valid;
`endif
        check(tag, "bus_req", {31'b0, sb_if.bus_req}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            check(tag, "bus_addr",   sb_if.bus_addr,            q[0].addr);
            check(tag, "bus_wdata",  sb_if.bus_wdata,           q[0].data);
            check(tag, "bus_byteen", {28'b0, sb_if.bus_byteen}, {28'b0, q[0].be});
        end
        check(tag, "st_exc",   {27'b0, sb_if.st_exc},   ades ? 32'd5 : 32'd0);
        check(tag, "st_stall", {31'b0, sb_if.st_stall}, {31'b0, stall});
        check(tag, "ld_stall", {31'b0, sb_if.ld_stall}, {31'b0, haz});
        if (push) e = model_pack(sb_if.st_addr, sb_if.st_data, size);
        @(posedge clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, STORE_NONE, 32'h0, 32'h0, 1'b0, rdy, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0, 1:    a = $urandom_range(0, 32'h2FFF);
            2:       a = 32'h7F00 + $urandom_range(0, 32'h1F);
            3:       a = 32'h7F20 + $urandom_range(0, 7);
            default: a = $urandom;
        endcase
        return a;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] op;
        case ($urandom_range(0, 3))
            0:       op = STORE_NONE;
            1:       op = STORE_W;
            2:       op = STORE_H;
            default: op = STORE_B;
        endcase
        return op;
    endfunction

    initial begin
        logic [31:0] last_addr;
        last_addr = 32'h0;

        // Reset held for three cycles
        rst_n = 1'b0;
        idle(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", "bus_req",    {31'b0, sb_if.bus_req},    32'd0);
        check("reset", "st_stall",   {31'b0, sb_if.st_stall},   32'd0);
        check("reset", "bus_addr",   sb_if.bus_addr,            32'd0);
        check("reset", "bus_wdata",  sb_if.bus_wdata,           32'd0);
        check("reset", "bus_byteen", {28'b0, sb_if.bus_byteen}, 32'd0);
        rst_n = 1'b1;
        q.delete();
        step("post_reset");

        // sb into the top lane of word 0x10
        drive(1'b1, STORE_B, 32'h0000_0013, 32'h1234_56AB, 1'b0, 1'b1, 1'b0, 32'h0);
        step("sb_push");
        check("sb_out", "bus_req",    {31'b0, sb_if.bus_req},    32'd1);
        check("sb_out", "bus_addr",   sb_if.bus_addr,            32'h0000_0010);
        check("sb_out", "bus_byteen", {28'b0, sb_if.bus_byteen}, 32'h8);
        check("sb_out", "bus_wdata",  sb_if.bus_wdata,           32'hABAB_ABAB);
        idle(1'b1);
        step("sb_drain");

        // Address legality
        drive(1'b1, STORE_H, 32'h7F04, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0);
        step("sh_timer");
        drive(1'b1, STORE_W, 32'h2FFD, 32'h1111_2222, 1'b0, 1'b1, 1'b0, 32'h0);
        step("sw_unaligned");
        drive(1'b1, STORE_W, 32'h7F08, 32'h3333_4444, 1'b0, 1'b1, 1'b0, 32'h0);
        step("sw_count");
        drive(1'b1, STORE_W, 32'h7F20, 32'h5555_6666, 1'b0, 1'b1, 1'b0, 32'h0);
        step("sw_ig");
        check("sw_ig", "bus_addr", sb_if.bus_addr, 32'h7F20);
        idle(1'b1);
        step("ig_drain");

        // Fill while the bridge is busy, then stall, then release
        drive(1'b1, STORE_W, 32'h0000_0100, 32'hA0A0_A0A0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("fill0");
        drive(1'b1, STORE_W, 32'h0000_0104, 32'hB1B1_B1B1, 1'b0, 1'b0, 1'b0, 32'h0);
        step("fill1");
        drive(1'b1, STORE_W, 32'h0000_0108, 32'hC2C2_C2C2, 1'b0, 1'b0, 1'b0, 32'h0);
        step("full_stall");
        drive(1'b1, STORE_W, 32'h0000_0108, 32'hC2C2_C2C2, 1'b0, 1'b1, 1'b0, 32'h0);
        step("full_pop_push");
        idle(1'b1);
        repeat (3) step("fill_drain");

        // Flushed store is dropped; buffered one still drains
        drive(1'b1, STORE_W, 32'h0000_0200, 32'hD3D3_D3D3, 1'b0, 1'b0, 1'b0, 32'h0);
        step("pre_flush");
        drive(1'b1, STORE_W, 32'h0000_0204, 32'hE4E4_E4E4, 1'b1, 1'b0, 1'b0, 32'h0);
        step("flushed");
        idle(1'b1);
        repeat (2) step("flush_drain");

        // Load against a buffered store to the same word
        drive(1'b1, STORE_W, 32'h0000_0100, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 32'h0);
        step("haz_store");
        drive(1'b0, STORE_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
        step("haz_load");
        drive(1'b0, STORE_NONE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
        step("haz_pop");
        step("haz_clear");

        // Reset while entries are pending drops them at once
        drive(1'b1, STORE_W, 32'h0000_0300, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, 32'h0);
        step("rst_fill0");
        drive(1'b1, STORE_B, 32'h0000_0305, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 32'h0);
        step("rst_fill1");
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset", "bus_req",  {31'b0, sb_if.bus_req}, 32'd0);
        check("mid_reset", "bus_addr", sb_if.bus_addr,         32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("after_mid_reset");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic        v, fl, rdy, ldv;
            logic [31:0] op, a, d, lda;
            v   = ($urandom_range(0, 9) < 7);
            op  = rand_op();
            a   = rand_addr();
            d   = $urandom;
            fl  = ($urandom_range(0, 9) == 0);
            rdy = $urandom_range(0, 1);
            ldv = $urandom_range(0, 1);
            lda = $urandom_range(0, 1) ? (last_addr ^ {30'b0, 2'($urandom_range(0, 3))}) : rand_addr();
            if (v) last_addr = a;
            drive(v, op, a, d, fl, rdy, ldv, lda);
            step("random");
        end

        idle(1'b1);
        repeat (3) step("final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- M-stage store path of the P7 pipelined MIPS CPU; the write-side counterpart of the load/immediate extension logic.
- Takes raw store requests (sb/sh/sw), checks address legality and alignment, then packs rt data into byte lanes with byte enables.
- Queues requests in a small FIFO and drains them to the data bus bridge over a req/ready handshake.
- Stalls the pipeline when the FIFO cannot accept a request.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- PTR_W, 1, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- st_valid  in  1  M stage holds a live instruction.
- st_op  in  32  store type: `STORE_none, `STORE_w, `STORE_h or `STORE_b.
- st_addr  in  32  byte address computed in E stage.
- st_data  in  32  forwarded rt value, unaligned.
- flush  in  1  exception or eret flush this cycle.
- ld_addr  in  32  M-stage load address; used only with the optional feature.
- ld_valid  in  1  M stage holds a load.
- st_stall  out  1  store cannot be accepted this cycle; combinational.
- st_exc  out  5  `EXC_AdES (5) for an illegal store, else 0; combinational.
- ld_stall  out  1  load conflicts with a buffered store.
- bus_req  out  1  head entry valid.
- bus_addr  out  32  word address of the head entry, {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-aligned data of the head entry.
- bus_byteen  out  4  byte enables of the head entry.
- bus_ready  in  1  bridge accepts the head entry this cycle.

Behaviour:
- Reset values: read pointer, write pointer and count = 0. All entries invalid. bus_req = 0; bus_addr, bus_wdata, bus_byteen = 0.
- Outputs st_stall, st_exc and ld_stall are 0 while there is no request.
- Lane packing:
  - sw: byteen = 1111; wdata = st_data.
  - sh: byteen = 0011 << (2*addr[1]); wdata = {2{st_data[15:0]}}.
  - sb: byteen = 0001 << addr[1:0]; wdata = {4{st_data[7:0]}}.
- AdES is raised, for an active store (st_valid && st_op != `STORE_none), when any of these holds:
  - sw with addr[1:0] != 0.
  - sh with addr[0] != 0.
  - Address outside DM 0x0000–0x2FFF, Timer0 0x7F00–0x7F0B, Timer1 0x7F10–0x7F1B and IG 0x7F20–0x7F23.
  - sh or sb into either timer range.
  - sw to a timer COUNT register (0x7F08 or 0x7F18).
- st_exc is asserted independent of FIFO state. An excepting store is never enqueued and never stalls.
- pop = bus_req && bus_ready.
- push = active store && !st_exc && !flush && !st_stall.
- st_stall = active store && !st_exc && !flush && count == DEPTH && !pop.
  - Pop while full frees a slot in the same cycle.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a store pushed in cycle N appears at the bus outputs at cycle N+1 if the FIFO was empty. One entry drains per bus_ready cycle.
- bus_* are driven from registered head storage.
- bus_addr, bus_wdata and bus_byteen hold stable while bus_req is high and bus_ready is low.
- flush does not discard already-buffered entries; committed stores always drain.
- Reset mid-drain drops all entries.

Optional Feature:
- Macro: STORE_LOAD_HAZARD_EN.
- With the macro: ld_stall = ld_valid && some valid entry has word address equal to ld_addr[31:2]. This prevents a load from bypassing an older buffered store.
- Without the macro: ld_stall is tied to 0 and no comparators are built.

Decomposition:
- constants.v holds:
  - the `STORE_* op encodings;
  - `EXC_AdES;
  - the address-map bounds (DM, Timer0, Timer1, IG);
  - the timer COUNT offset.
- Sub-module m_store_align: combinational; maps (st_op, st_addr, st_data) to (byteen, wdata, exc). The top module holds only the FIFO, handshake and hazard logic.

Test Plan:
- Reset low for 3 cycles, then release → bus_req = 0, st_stall = 0; bus outputs all 0.
- sb addr 0x0000_0013, data 0x1234_56AB, bus_ready = 1 → next cycle bus_addr = 0x10, byteen = 1000, wdata = 0xABAB_ABAB.
- sh addr 0x7F04 → st_exc = 5, no push. sw addr 0x2FFD → st_exc = 5. sw addr 0x7F08 → st_exc = 5. sw addr 0x7F20 → accepted.
- bus_ready = 0, three sw back-to-back → first two accepted, third gets st_stall = 1. Raising bus_ready in that cycle clears st_stall and accepts the third. Drain order matches issue order.
- Store with flush = 1 → not enqueued. Buffered entries still drain with correct data.
- With STORE_LOAD_HAZARD_EN: buffer sw 0x100 (bus_ready = 0), load 0x102 → ld_stall = 1. After the pop → ld_stall = 0. Without the macro → ld_stall always 0.
